// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and RAM port bundle for mem_access_ctrl.
// slave = controller side, master = requester/RAM side.
interface mem_access_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [WIDTH-1:0] req_addr_i;
  logic [WIDTH-1:0] req_wdata_i;
  logic             resp_valid_o;
  logic [WIDTH-1:0] resp_rdata_o;
  logic             resp_err_o;
  logic [WIDTH-1:0] mem_a_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_wd_o;
  logic [WIDTH-1:0] mem_rd_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rd_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_a_o, mem_we_o, mem_wd_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rd_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_a_o, mem_we_o, mem_wd_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-access load/store controller with byte/half read-modify-write.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] cap_q, cap_d;

  logic             ready;
  logic             resp_valid;
  logic             resp_err;
  logic [WIDTH-1:0] resp_rdata;
  logic [WIDTH-1:0] mem_a;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] ld_ext;
  logic             misalign;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0])
                 || ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00))
                 ||  (bus.req_size_i == 2'b11);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = {{(WIDTH-8){~uns_q & cap_q[7]}}, cap_q[7:0]};
      2'b01:   ld_ext = {{(WIDTH-16){~uns_q & cap_q[15]}}, cap_q[15:0]};
      default: ld_ext = cap_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          err_d   = misalign;
          // Sub-word stores must fetch the surrounding word before writing it back.
          if (misalign)
            state_d = RESP;
          else if (bus.req_we_i && (bus.req_size_i[1] == 1'b0))
            state_d = READ;
          else if (bus.req_we_i)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        mem_a   = addr_q;
        cap_d   = bus.mem_rd_i;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_a  = addr_q;
        mem_we = 1'b1;
        unique case (size_q)
          2'b00:   mem_wd = {cap_q[WIDTH-1:8], wdata_q[7:0]};
          2'b01:   mem_wd = {cap_q[WIDTH-1:16], wdata_q[15:0]};
          default: mem_wd = wdata_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = ld_ext;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_err_o   = resp_err;
  assign bus.resp_rdata_o = resp_rdata;
  assign bus.mem_a_o      = mem_a;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_wd_o     = mem_wd;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have clk_i input 1: single clock; all state updates on the posedge.
REQ-003 SHALL have rst_ni input 1: reset, asynchronous and active-low.
REQ-004 SHALL have req_valid_i input 1: access request present.
REQ-005 SHALL have req_ready_o output 1: controller can accept a request.
REQ-006 SHALL have req_we_i input 1: 1 = store, 0 = load.
REQ-007 SHALL have req_size_i input 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have req_unsigned_i input 1: load zero-extend (1) or sign-extend (0).
REQ-009 SHALL have req_addr_i input WIDTH: byte address.
REQ-010 SHALL have req_wdata_i input WIDTH: store data, low-aligned.
REQ-011 SHALL have resp_valid_o output 1: one-cycle completion pulse.
REQ-012 SHALL have resp_rdata_o output WIDTH: extended load data.
REQ-013 SHALL have resp_err_o output 1: access rejected; valid with resp_valid_o.
REQ-014 SHALL have mem_a_o output WIDTH: byte address to RAM.
REQ-015 SHALL have mem_we_o output 1: RAM write enable.
REQ-016 SHALL have mem_wd_o output WIDTH: RAM write word, byte 0 at mem_a_o.
REQ-017 SHALL have mem_rd_i input WIDTH: combinational RAM read word, byte 0 at mem_a_o.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-019 SHALL drive req_ready_o=1 only in IDLE; accept on a posedge with req_valid_i & req_ready_o, registering we, size, unsigned, addr and wdata.
REQ-020 SHALL transition on acceptance: load -> READ; store of byte/half -> READ; store of word -> WRITE.
REQ-021 SHALL drive mem_a_o from the registered address in READ and WRITE, and drive 0 in IDLE and RESP.
REQ-022 SHALL in READ capture mem_rd_i into an internal word register at the cycle end, then go to RESP for a load or WRITE for a store.
REQ-023 SHALL in WRITE assert mem_we_o for exactly one cycle, then go to RESP.
REQ-024 SHALL in WRITE drive mem_wd_o as: word = wdata; half = {captured[31:16], wdata[15:0]}; byte = {captured[31:8], wdata[7:0]}.
REQ-025 SHALL drive mem_wd_o=0 outside WRITE.
REQ-026 SHALL in RESP assert resp_valid_o for one cycle, then return to IDLE; resp_valid_o has no backpressure.
REQ-027 SHALL for loads in RESP present resp_rdata_o as byte = captured[7:0] and half = captured[15:0], sign- or zero-extended per req_unsigned_i; word = captured; stores present 0.
REQ-028 SHALL have latency from acceptance edge to resp_valid_o: load 2 cycles, word store 2 cycles, byte/half store 3 cycles.
REQ-029 SHALL ignore req_valid_i outside IDLE; it does not queue.
REQ-030 SHALL hold resp_rdata_o and resp_err_o at 0 whenever resp_valid_o=0.

Reset
REQ-031 SHALL on rst_ni low, immediately and regardless of clock, force state IDLE, req_ready_o=1, and all other outputs and internal registers to 0.
REQ-032 SHALL on reset mid-operation (READ/WRITE/RESP) abandon the access: mem_we_o drops at once and no response is issued for that access.
REQ-033 SHALL permit acceptance on the first posedge after rst_ni deasserts.

Configuration
REQ-034 SHALL, with macro MEM_ACCESS_MISALIGN_TRAP_EN defined, route half with addr[0]=1, word with addr[1:0]!=0, or size 11 from IDLE directly to RESP with resp_err_o=1, with no READ or WRITE and mem_we_o never asserted.
REQ-035 SHALL, with the macro undefined, tie resp_err_o to 0, treat size 11 as word, and perform every access at the given unaligned address unchanged.

Verification
REQ-036 SHALL cover: RAM bytes 0x10..0x13 = 80 7F 00 11; load byte signed @0x10 -> resp_rdata_o=0xFFFFFF80 two cycles after acceptance; load half unsigned @0x10 -> 0x00007F80.
REQ-037 SHALL cover: word store 0xDEADBEEF @0x20 -> one mem_we_o cycle, mem_wd_o=0xDEADBEEF, resp_valid_o two cycles after acceptance; subsequent load word @0x20 -> 0xDEADBEEF.
REQ-038 SHALL cover: RAM @0x20 = 0xDEADBEEF; byte store 0x55 @0x20 -> READ then WRITE with mem_wd_o=0xDEADBE55, resp_valid_o three cycles after acceptance.
REQ-039 SHALL cover: with the macro defined, word load @0x22 -> resp_valid_o=1, resp_err_o=1 one cycle after acceptance, mem_we_o=0 throughout; with it undefined -> normal load returning bytes 0x22..0x25.
REQ-040 SHALL cover: byte store @0x30, rst_ni low during WRITE -> mem_we_o falls asynchronously, no resp_valid_o, req_ready_o=1, RAM @0x30 unchanged if the write edge was not reached.
REQ-041 SHALL cover: req_valid_i held high continuously for two loads -> second accepted only after RESP, with back-to-back responses three cycles apart.
